// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared combinational ALU with a one-entry response register.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             hz100,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [5:0]       req0_op,
  input  logic [5:0]       req1_op,
  output logic [1:0]       req_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [5:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_negative,
  input  logic             alu_zero,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_negative,
  output logic             resp_zero,
  output logic             resp_err
);

  localparam logic [5:0] CU_ADD   = 6'd28;
  localparam logic [5:0] CU_AND   = 6'd37;
  localparam logic [5:0] CU_ERROR = 6'd38;

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  typedef struct packed {
    logic             id;
    logic [WIDTH-1:0] result;
    logic             negative;
    logic             zero;
    logic             err;
  } resp_t;

  state_t     state, state_nxt;
  resp_t      resp_q, resp_d;
  logic [1:0] grant;
  logic       gnt_id;
  logic       slot_free;
  logic       accept;
  logic       legal_op;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic ptr;

  // On conflict the pointer picks the winner; it then points at the loser.
  always_comb begin
    grant = req_valid;
    if (req_valid == 2'b11) grant = ptr ? 2'b10 : 2'b01;
  end

  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset)      ptr <= 1'b0;
    else if (accept) ptr <= ~gnt_id;
  end
`else
  always_comb begin
    grant = {req_valid[1] & ~req_valid[0], req_valid[0]};
  end
`endif

  assign gnt_id    = grant[1];
  assign slot_free = (state == IDLE) | resp_ready;
  // Gate with reset so nothing is offered while the block is held in reset.
  assign req_ready = grant & {2{slot_free & reset}};
  assign accept    = |req_ready;

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = CU_ERROR;
    if (accept) begin
      alu_a  = gnt_id ? req1_a  : req0_a;
      alu_b  = gnt_id ? req1_b  : req0_b;
      alu_op = gnt_id ? req1_op : req0_op;
    end
  end

  assign legal_op = (alu_op >= CU_ADD) && (alu_op <= CU_AND);

  // Illegal ops are consumed but report an error with all flags cleared.
  always_comb begin
    resp_d.id       = gnt_id;
    resp_d.result   = legal_op ? alu_result : '0;
    resp_d.negative = legal_op & alu_negative;
    resp_d.zero     = legal_op & alu_zero;
    resp_d.err      = ~legal_op;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RESP;
      RESP:    if (resp_ready && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset)      resp_q <= '0;
    else if (accept) resp_q <= resp_d;
  end

  assign resp_valid    = (state == RESP);
  assign resp_id       = resp_q.id;
  assign resp_result   = resp_q.result;
  assign resp_negative = resp_q.negative;
  assign resp_zero     = resp_q.zero;
  assign resp_err      = resp_q.err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; includes a small ALU model on the shared-ALU ports.
module tb_alu_arbiter;
  localparam int WIDTH = 32;

  logic             hz100, reset;
  logic [1:0]       req_valid, req_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [5:0]       req0_op, req1_op, alu_op;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result, resp_result;
  logic             alu_negative, alu_zero;
  logic             resp_valid, resp_ready, resp_id, resp_negative, resp_zero, resp_err;

  int n_cmp = 0;
  int n_bad = 0;

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .hz100(hz100), .reset(reset), .req_valid(req_valid),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op), .req_ready(req_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_negative(alu_negative), .alu_zero(alu_zero),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_negative(resp_negative),
    .resp_zero(resp_zero), .resp_err(resp_err)
  );

  initial hz100 = 1'b0;
  always #5 hz100 = ~hz100;

  // Shared ALU: unsupported ops return a junk value so the error path must mask it.
  always_comb begin
    case (alu_op)
      6'd28:   alu_result = alu_a + alu_b;
      6'd29:   alu_result = alu_a - alu_b;
      6'd36:   alu_result = alu_a | alu_b;
      6'd37:   alu_result = alu_a & alu_b;
      default: alu_result = 32'hDEAD_BEEF;
    endcase
    alu_negative = alu_result[WIDTH-1];
    alu_zero     = (alu_result == '0);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hz100);
    #1;
  endtask

  task automatic drv0(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op);
    req0_a = a; req0_b = b; req0_op = op;
  endtask

  task automatic drv1(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op);
    req1_a = a; req1_b = b; req1_op = op;
  endtask

  initial begin
    logic [1:0] rdy_exp;
    logic       id_exp;
    reset = 1'b0; req_valid = 2'b01; resp_ready = 1'b1;
    drv0(0, 0, 0); drv1(0, 0, 0);
    #2;
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_result", resp_result, 0);
    chk("rst_id_flags", {resp_id, resp_negative, resp_zero, resp_err}, 4'b0000);
    req_valid = 2'b00;
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("idle_alu_op", alu_op, 6'd38);
    chk("idle_alu_ab", {alu_a, alu_b}, 64'd0);

    // Basic add
    req_valid = 2'b01; drv0(10, 15, 6'd28);
    #1;
    chk("add_req_ready", req_ready, 2'b01);
    chk("add_alu_a", alu_a, 10);
    tick();
    chk("add_resp_valid", resp_valid, 1'b1);
    chk("add_id", resp_id, 1'b0);
    chk("add_result", resp_result, 25);
    chk("add_nz", {resp_negative, resp_zero, resp_err}, 3'b000);

    // Back-to-back subtracts
    drv0(5, 5, 6'd29);
    #1;
    chk("sub0_req_ready", req_ready, 2'b01);
    tick();
    chk("sub0_result", resp_result, 0);
    chk("sub0_zero", {resp_negative, resp_zero}, 2'b01);
    drv0(3, 7, 6'd29);
    tick();
    chk("subneg_result", resp_result, 32'hFFFF_FFFC);
    chk("subneg_flags", {resp_negative, resp_zero}, 2'b10);
    req_valid = 2'b00;
    tick();
    chk("drain_valid", resp_valid, 1'b0);

    // Illegal op then OR, both from requester 1
    req_valid = 2'b10; drv1(5, 6, 6'd2);
    #1;
    chk("jal_req_ready", req_ready, 2'b10);
    tick();
    chk("jal_valid_id", {resp_valid, resp_id}, 2'b11);
    chk("jal_result", resp_result, 0);
    chk("jal_flags", {resp_negative, resp_zero, resp_err}, 3'b001);
    drv1(32'hF0, 32'h0F, 6'd36);
    tick();
    chk("or_result", resp_result, 32'hFF);
    chk("or_err", resp_err, 1'b0);
    req_valid = 2'b00;
    tick();

    // Conflict: both valid for 4 accepts
    req_valid = 2'b11; drv0(1, 1, 6'd28); drv1(2, 2, 6'd28);
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      id_exp = i[0];
`else
      id_exp = 1'b0;
`endif
      rdy_exp = id_exp ? 2'b10 : 2'b01;
      #1;
      chk("arb_req_ready", req_ready, rdy_exp);
      tick();
      chk("arb_id", resp_id, id_exp);
      chk("arb_result", resp_result, id_exp ? 4 : 2);
    end
    req_valid = 2'b00;
    tick();

    // Backpressure
    resp_ready = 1'b0; req_valid = 2'b01; drv0(4, 4, 6'd28);
    tick();
    chk("bp_first", {resp_valid, resp_id}, 2'b10);
    req_valid = 2'b10; drv1(9, 2, 6'd29);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_req_ready", req_ready, 2'b00);
      tick();
      chk("bp_hold_vid", {resp_valid, resp_id}, 2'b10);
      chk("bp_hold_result", resp_result, 8);
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_release_ready", req_ready, 2'b10);
    tick();
    chk("bp_next_vid", {resp_valid, resp_id}, 2'b11);
    chk("bp_next_result", resp_result, 7);

    // Reset while a response is pending
    req_valid = 2'b00; resp_ready = 1'b0;
    #2;
    chk("pre_rst_valid", resp_valid, 1'b1);
    reset = 1'b0;
    #1;
    chk("midrst_valid", resp_valid, 1'b0);
    chk("midrst_result", resp_result, 0);
    chk("midrst_flags", {resp_id, resp_negative, resp_zero, resp_err}, 4'b0000);
    tick();
    reset = 1'b1; resp_ready = 1'b1;
    req_valid = 2'b01; drv0(1, 2, 6'd28);
    #1;
    chk("post_rst_ready", req_ready, 2'b01);
    tick();
    chk("post_rst_resp", {resp_valid, resp_id}, 2'b10);
    chk("post_rst_result", resp_result, 3);
    req_valid = 2'b00;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits.
REQ-002 SHALL have port: hz100  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have ports: req_valid[1:0]  input  2  per-requester request valid (0 = execute stage, 1 = branch/address unit).
REQ-005 SHALL have ports: req0_a, req0_b, req1_a, req1_b  input  WIDTH each  requester operands.
REQ-006 SHALL have ports: req0_op, req1_op  input  6 each  cuOPType encoding of requested operation.
REQ-007 SHALL have port: req_ready  output  2  per-requester accept; transfer when req_valid[i] & req_ready[i].
REQ-008 SHALL have ports: alu_a, alu_b  output  WIDTH; alu_op  output  6  drive of the shared ALU.
REQ-009 SHALL have ports: alu_result  input  WIDTH; alu_negative, alu_zero  input  1  shared ALU outputs (combinational).
REQ-010 SHALL have ports: resp_valid  output  1; resp_ready  input  1; resp_id  output  1; resp_result  output  WIDTH; resp_negative, resp_zero, resp_err  output  1.

Function
REQ-011 SHALL implement a 2-state FSM: IDLE (response register empty), RESP (response register holds unconsumed result).
REQ-012 SHALL compute slot_free = (state == IDLE) | resp_ready.
REQ-013 SHALL grant at most one requester per cycle; req_ready[i] = slot_free & grant[i]; grant only to a requester with req_valid high.
REQ-014 SHALL, on an accepted request, drive alu_a/alu_b/alu_op combinationally from the granted requester in the same cycle, and capture alu_result/alu_negative/alu_zero and grant id into the response register on that clock edge (latency 1 cycle).
REQ-015 SHALL, with no accepted request, drive alu_a = 0, alu_b = 0, alu_op = 6'd38 (CU_ERROR).
REQ-016 SHALL treat legal ops as 6'd28..6'd37 (CU_ADD..CU_AND); an accepted illegal op SHALL still be consumed, with resp_result = 0, resp_negative = 0, resp_zero = 0, resp_err = 1.
REQ-017 SHALL transition IDLE->RESP on accept; RESP->IDLE on resp_ready with no accept; RESP->RESP on resp_ready with accept (back-to-back, one response per cycle); RESP holds otherwise.
REQ-018 SHALL hold resp_id/resp_result/resp_negative/resp_zero/resp_err stable while resp_valid & !resp_ready.
REQ-019 SHALL assert resp_valid exactly when state == RESP.
REQ-020 SHALL ignore req_valid deassertion without handshake (no internal request buffering); requesters hold operands stable until accepted.
REQ-021 SHALL, when both req_valid bits are high in one accept cycle, grant per REQ-026/REQ-027 and leave the loser's req_ready low.

Reset
REQ-022 SHALL, while reset == 0, force state = IDLE, resp_valid = 0, resp_id = 0, resp_result = 0, resp_negative = 0, resp_zero = 0, resp_err = 0, priority pointer = 0, asynchronously.
REQ-023 SHALL discard any in-flight response on reset mid-operation; req_ready SHALL be 0 while reset == 0.
REQ-024 SHALL resume normal accept on the first rising edge after reset deasserts.

Configuration
REQ-025 SHALL use macro ALU_ARB_ROUND_ROBIN_EN to select arbitration policy.
REQ-026 SHALL, with ALU_ARB_ROUND_ROBIN_EN defined, keep a 1-bit priority pointer (reset 0) favouring that requester on conflict, set to the non-granted requester after every accept.
REQ-027 SHALL, without ALU_ARB_ROUND_ROBIN_EN, use fixed priority: requester 0 always wins; no pointer register.

Verification
REQ-028 SHALL cover: reset released, req_valid=01, req0 a=10 b=15 op=28 -> req_ready=01 same cycle, next cycle resp_valid=1 id=0 result=25 zero=0 negative=0.
REQ-029 SHALL cover: req0 a=5 b=5 op=29 accepted -> result=0 zero=1; then req0 a=3 b=7 op=29 -> result=0xFFFFFFFC negative=1.
REQ-030 SHALL cover: req_valid=11 held 4 accept cycles, resp_ready=1 -> ids 0,1,0,1 with _EN defined; ids 0,0,0,0 without.
REQ-031 SHALL cover: resp_ready=0 after one accept, req_valid=10 -> req_ready=00 and response stable 3 cycles; resp_ready=1 -> req1 accepted same cycle, next response id=1.
REQ-032 SHALL cover: req1 op=2 (CU_JAL) accepted -> resp_err=1 result=0; following op=36 a=0xF0 b=0x0F -> result=0xFF resp_err=0.
REQ-033 SHALL cover: reset asserted while resp_valid=1 -> resp_valid=0 immediately (before next edge), all response outputs 0.
